bin2bcd_disp: RTL

- Downstream display stage for the calculator datapath (power, multiply and other result producers).
- Takes a 14-bit unsigned result and converts it to 5 BCD digits using sequential shift-add-3 (double dabble), one bit per clock.
- Drives five active-low 7-segment digits on the Cyclone II board, with optional leading-zero blanking.
- A start/busy/done handshake lets the result producer or the top-level controller launch one conversion at a time.

---
 rtl/bin2bcd_disp_pkg.sv | 32 +++
 rtl/bin2bcd_disp_if.sv | 28 ++
 rtl/bin2bcd_disp_seg7_dec.sv | 20 ++
 rtl/bin2bcd_disp.sv | 124 ++++++++++++
 4 files changed

// File: rtl/bin2bcd_disp_pkg.sv
// Shared definitions for the binary-to-BCD display stage: default widths,
// FSM state encoding, 7-segment constants and the add-3 helper.
package bin2bcd_disp_pkg;

  localparam int IN_W_DEF   = 14;
  localparam int DIGITS_DEF = 5;

  // State encoding kept as explicit constants so other blocks can decode it.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_t;

  // Active-low segments, bit order gfedcba.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Double-dabble correction: a digit of 5..9 gets +3 before the shift.
  // The sum never exceeds 12, so the carry out of the 4-bit add is dropped.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_disp_if.sv
// Handshake and display bus between a result producer (master) and the
// binary-to-BCD display stage (slave).
interface bin2bcd_disp_if
  import bin2bcd_disp_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
);

  logic                  start;
  logic [IN_W-1:0]       bin;
  logic                  blank;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output start, bin, blank,
    input  busy, done, bcd, seg
  );

  modport slave (
    input  start, bin, blank,
    output busy, done, bcd, seg
  );

endinterface

// File: rtl/bin2bcd_disp_seg7_dec.sv
// One BCD digit to active-low 7-segment (gfedcba), with a forced-blank input.
// Codes 10..15 cannot come out of the converter; they show as blank.
module seg7_dec
  import bin2bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup for valid digits, blank otherwise.
  always_comb begin
    // NOTE: every output of an always_comb is given a default first so no latch is inferred.
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/bin2bcd_disp.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// driving DIGITS active-low 7-segment digits with optional leading-zero
// blanking. One conversion at a time under a start/busy/done handshake.
module bin2bcd_disp
  import bin2bcd_disp_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
)(
  input  logic           clk,
  input  logic           rst,
  bin2bcd_disp_if.slave  bus
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_t               state, state_next;
  logic [IN_W-1:0]      shreg, shreg_next;
  logic [BCD_W-1:0]     scratch, scratch_next;
  logic [CNT_W-1:0]     count, count_next;
  logic [BCD_W-1:0]     bcd_q, bcd_next;
  logic                 busy_q, busy_next;
  logic                 done_q, done_next;

  logic [BCD_W-1:0]      adj;
  logic [BCD_W+IN_W-1:0] shifted;
  logic [DIGITS-1:0]     dig_blank;
  logic [7*DIGITS-1:0]   seg_w;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and datapath: accept in IDLE, one add-3/shift step per SHIFT cycle.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    scratch_next = scratch;
    count_next   = count;
    bcd_next     = bcd_q;
    busy_next    = busy_q;
    done_next    = 1'b0;

    // All digits corrected in parallel, then the whole chain shifts left.
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = add3(scratch[4*i +: 4]);
    end
    shifted = {adj, shreg} << 1;

    case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (bus.start) begin
          shreg_next   = bus.bin;
          scratch_next = '0;
          count_next   = '0;
          busy_next    = 1'b1;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_next, shreg_next} = shifted;
        count_next = count + CNT_W'(1);
        // This edge performs the last shift: publish the result.
        if (count == CNT_W'(IN_W - 1)) begin
          bcd_next   = shifted[BCD_W+IN_W-1 -: BCD_W];
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and handshake registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      scratch <= '0;
      count   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shreg   <= shreg_next;
      scratch <= scratch_next;
      count   <= count_next;
      bcd_q   <= bcd_next;
      busy_q  <= busy_next;
      done_q  <= done_next;
    end
  end

  // Leading-zero chain: a digit blanks if it and every higher digit are zero.
  always_comb begin
    logic run;
    dig_blank = '0;
    run = bus.blank;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run = run & (bcd_q[4*i +: 4] == 4'd0);
      dig_blank[i] = run;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_dec u_dec (
      .digit (bcd_q[4*g +: 4]),
      .blank (dig_blank[g]),
      .seg   (seg_w[7*g +: 7])
    );
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.seg  = seg_w;

endmodule
